// File: rtl/trs_char_renderer.sv
// TRS-80 64x16 text/block-graphics pixel source for a 640x480 frame.
// Five-stage pipeline: VRAM fetch, font fetch, pixel decode; rgb lags cx/cy by LATENCY cycles.
module trs_char_renderer #(
  parameter int          X_START    = 64,
  parameter int          Y_START    = 48,
  parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
  parameter logic [23:0] BG_RGB     = 24'h000000,
  parameter logic [23:0] BORDER_RGB = 24'h000000,
  parameter int          LATENCY    = 5
) (
  input  logic        clk_pixel,
  input  logic        resetn,
  input  logic [9:0]  cx,
  input  logic [9:0]  cy,
  input  logic        mode32,
  output logic [9:0]  vram_addr,
  input  logic [7:0]  vram_data,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  output logic [23:0] rgb
);

  if (LATENCY != 5) begin : g_latency_check
    $error("trs_char_renderer: pipeline depth is fixed at 5 cycles");
  end

  localparam logic [9:0] X0 = 10'(X_START);
  localparam logic [9:0] X1 = 10'(X_START + 512);
  localparam logic [9:0] Y0 = 10'(Y_START);
  localparam logic [9:0] Y1 = 10'(Y_START + 384);

  logic [3:0] row;
  logic [4:0] line;
  logic       in_window;
  logic [8:0] hx;
  logic [5:0] col;
  logic [2:0] px;

  assign in_window = (cx >= X0) && (cx < X1) && (cy >= Y0) && (cy < Y1);
  assign hx        = cx[8:0] - X0[8:0];

  // Double-width mode fetches only even cells and stretches each pixel over two columns.
  always_comb begin
    col = hx[8:3];
    px  = hx[2:0];
    if (mode32) begin
      col = {hx[8:4], 1'b0};
      px  = hx[3:1];
    end
  end

  // Row/line tracked incrementally once per line (cx==0) instead of dividing vy by 24.
  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      row  <= '0;
      line <= '0;
    end else if (cx == 10'd0) begin
      if (cy == Y0) begin
        row  <= '0;
        line <= '0;
      end else if (cy > Y0 && cy < Y1) begin
        if (line == 5'd23) begin
          line <= '0;
          row  <= row + 4'd1;
        end else begin
          line <= line + 5'd1;
        end
      end
    end
  end

  logic       s1_win, s2_win, s3_win, s4_win;
  logic [2:0] s1_px, s2_px, s3_px, s4_px;
  logic [4:0] s1_line, s2_line, s3_line, s4_line;
  logic [7:0] s3_code, s4_code;

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) begin
      vram_addr <= '0;
      font_addr <= '0;
      s1_win    <= 1'b0;
      s2_win    <= 1'b0;
      s3_win    <= 1'b0;
      s4_win    <= 1'b0;
      s1_px     <= '0;
      s2_px     <= '0;
      s3_px     <= '0;
      s4_px     <= '0;
      s1_line   <= '0;
      s2_line   <= '0;
      s3_line   <= '0;
      s4_line   <= '0;
      s3_code   <= '0;
      s4_code   <= '0;
    end else begin
      if (in_window) vram_addr <= {row, col};
      s1_win  <= in_window;
      s1_px   <= px;
      s1_line <= line;

      s2_win  <= s1_win;
      s2_px   <= s1_px;
      s2_line <= s1_line;

      if (s2_win) font_addr <= {vram_data[6:0], s2_line[4:1]};
      s3_code <= vram_data;
      s3_win  <= s2_win;
      s3_px   <= s2_px;
      s3_line <= s2_line;

      s4_code <= s3_code;
      s4_win  <= s3_win;
      s4_px   <= s3_px;
      s4_line <= s3_line;
    end
  end

  logic [1:0]  band;
  logic        pix_on;
  logic [23:0] pix_rgb;

  // Block graphics: 2x3 grid, bit index = band*2 + right-half.
  always_comb begin
    band = 2'd0;
    if (s4_line >= 5'd16)     band = 2'd2;
    else if (s4_line >= 5'd8) band = 2'd1;
    if (s4_code[7:6] == 2'b10) pix_on = s4_code[{band, s4_px[2]}];
    else                       pix_on = font_data[3'd7 - s4_px];
    if (!s4_win)     pix_rgb = BORDER_RGB;
    else if (pix_on) pix_rgb = FG_RGB;
    else             pix_rgb = BG_RGB;
  end

  always_ff @(posedge clk_pixel or negedge resetn) begin
    if (!resetn) rgb <= '0;
    else         rgb <= pix_rgb;
  end

endmodule

// File: tb/tb_trs_char_renderer.sv
// Bench for trs_char_renderer: behavioural VRAM/font ROM, directed vectors and
// a delay line that compares rgb five cycles after each presented pixel.
module tb_trs_char_renderer;

  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;
  localparam logic [23:0] BD = 24'h000000;

  logic        clk_pixel = 1'b0;
  logic        resetn    = 1'b0;
  logic [9:0]  cx        = '0;
  logic [9:0]  cy        = '0;
  logic        mode32    = 1'b0;
  logic [9:0]  vram_addr;
  logic [7:0]  vram_data;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [23:0] rgb;

  trs_char_renderer dut (
    .clk_pixel(clk_pixel), .resetn(resetn), .cx(cx), .cy(cy), .mode32(mode32),
    .vram_addr(vram_addr), .vram_data(vram_data),
    .font_addr(font_addr), .font_data(font_data), .rgb(rgb)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [7:0] vram [1024];
  logic [7:0] font [2048];
  always @(posedge clk_pixel) vram_data <= vram[vram_addr];
  always @(posedge clk_pixel) font_data <= font[font_addr];

  typedef struct {
    int          x;
    int          y;
    bit          m;
    logic [23:0] e;
  } vec_t;
  vec_t tbl[14];

  int          total = 0;
  int          bad   = 0;
  int          cur_y = 0;
  logic [23:0] exp_p[5];
  bit          chk_p[5];
  bit          mon = 0;
  bit          odd_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cx=%0d cy=%0d)", name, act, req, cx, cy);
    end
  endtask

  // Reference: direct division of the window coordinates.
  function automatic logic [23:0] model(input int x, input int y, input bit m);
    int hx, vy, r, ln, c, p, band;
    logic [7:0] code, glyph;
    if (x < 64 || x >= 576 || y < 48 || y >= 432) return BD;
    hx = x - 64; vy = y - 48; r = vy / 24; ln = vy % 24;
    c  = m ? (hx / 16) * 2 : hx / 8;
    p  = m ? (hx % 16) / 2 : hx % 8;
    code = vram[r * 64 + c];
    if (code[7:6] == 2'b10) begin
      band = ln / 8;
      return code[band * 2 + p / 4] ? FG : BG;
    end
    glyph = font[{code[6:0], 4'(ln / 2)}];
    return glyph[7 - p] ? FG : BG;
  endfunction

  task automatic step(input int x, input int y, input bit m, input bit chk, input logic [23:0] e);
    cx = 10'(x); cy = 10'(y); mode32 = m;
    for (int i = 4; i > 0; i--) begin
      exp_p[i] = exp_p[i-1];
      chk_p[i] = chk_p[i-1];
    end
    exp_p[0] = e; chk_p[0] = chk;
    @(posedge clk_pixel); #1;
    if (chk_p[4]) check("rgb", {8'h0, rgb}, {8'h0, exp_p[4]});
    if (mon && vram_addr[0]) odd_seen = 1;
  endtask

  task automatic step_m(input int x, input int y, input bit m);
    step(x, y, m, 1, model(x, y, m));
  endtask

  task automatic flush(input int y);
    repeat (5) step(1, y, 0, 1, BD);
  endtask

  task automatic goto_line(input int y);
    if (y < cur_y || cur_y < 48) begin
      step_m(0, 48, 0);
      cur_y = 48;
    end
    while (cur_y < y) begin
      cur_y++;
      step_m(0, cur_y, 0);
    end
  endtask

  task automatic run(input int y, input int x0, input int x1, input bit m);
    goto_line(y);
    for (int x = x0; x <= x1; x++) step_m(x, y, m);
    flush(y);
  endtask

  initial begin
    for (int i = 0; i < 5; i++) begin
      exp_p[i] = '0;
      chk_p[i] = 0;
    end
    for (int i = 0; i < 1024; i++) vram[i] = 8'h41;
    for (int i = 0; i < 2048; i++) font[i] = 8'h80;

    tbl[0]  = '{64, 48, 0, FG};   tbl[1]  = '{65, 48, 0, BG};
    tbl[2]  = '{72, 48, 0, FG};   tbl[3]  = '{71, 60, 0, BG};
    tbl[4]  = '{568, 431, 0, FG}; tbl[5]  = '{575, 431, 0, BG};
    tbl[6]  = '{576, 100, 0, BD}; tbl[7]  = '{63, 48, 0, BD};
    tbl[8]  = '{64, 47, 0, BD};   tbl[9]  = '{64, 432, 0, BD};
    tbl[10] = '{64, 48, 1, FG};   tbl[11] = '{65, 48, 1, FG};
    tbl[12] = '{66, 48, 1, BG};   tbl[13] = '{80, 300, 1, FG};

    repeat (3) @(posedge clk_pixel);
    #1;
    check("reset_rgb", {8'h0, rgb}, 32'h0);
    check("reset_vram_addr", {22'h0, vram_addr}, 32'h0);
    check("reset_font_addr", {21'h0, font_addr}, 32'h0);
    resetn = 1'b1;

    for (int i = 0; i < 14; i++) begin
      goto_line(tbl[i].y);
      step(tbl[i].x, tbl[i].y, tbl[i].m, 1, tbl[i].e);
      flush(tbl[i].y);
    end

    run(48, 56, 100, 0);
    run(200, 560, 580, 0);

    // Address sweep, last row, and no counter change on line 432.
    goto_line(120);
    step_m(104, 120, 0);
    check("vram_addr_197", {22'h0, vram_addr}, 32'd197);
    flush(120);
    goto_line(431);
    step_m(64, 431, 0);
    check("vram_addr_row15", {22'h0, vram_addr}, 32'd960);
    flush(431);
    goto_line(432);
    step(64, 431, 0, 1, FG);
    check("vram_addr_hold_432", {22'h0, vram_addr}, 32'd960);
    flush(431);

    // Block graphics: 0x81 top-left, 0x94 middle-left + bottom-left.
    vram[0] = 8'h81; vram[1] = 8'h94;
    foreach (tbl[k]) begin end
    for (int vi = 0; vi < 6; vi++) begin
      int vy;
      case (vi)
        0: vy = 0;  1: vy = 7;  2: vy = 8;
        3: vy = 15; 4: vy = 16; default: vy = 23;
      endcase
      goto_line(48 + vy);
      for (int h = 0; h < 16; h++) begin
        logic [23:0] e;
        if (h < 8) e = (h < 4 && vy < 8) ? FG : BG;
        else       e = ((h - 8) < 4 && vy >= 8) ? FG : BG;
        step(64 + h, 48 + vy, 0, 1, e);
      end
      flush(48 + vy);
    end

    // Double-width: cell 0 solid, cell 1 blank and must never be fetched.
    vram[0] = 8'h7F; vram[1] = 8'h00; vram[2] = 8'h00;
    for (int r = 0; r < 16; r++) begin
      font[{7'h7F, 4'(r)}] = 8'hFF;
      font[{7'h00, 4'(r)}] = 8'h00;
    end
    goto_line(48);
    step(64, 48, 0, 1, FG);
    mon = 1;
    for (int h = 0; h < 16; h++) step(64 + h, 48, 1, 1, FG);
    for (int h = 16; h < 48; h++) step_m(64 + h, 48, 1);
    mon = 0;
    flush(48);
    check("mode32_no_odd_addr", {31'h0, odd_seen}, 32'h0);

    // Mode toggled pixel by pixel: each pixel keeps the mode it was presented with.
    for (int h = 0; h < 20; h++) step_m(64 + h, 48, h[0]);
    flush(48);

    // 0xC1 aliases to the 0x41 glyph.
    vram[0] = 8'h41; vram[1] = 8'h41; vram[2] = 8'hC1; vram[3] = 8'h41;
    font[11'h412] = 8'hCA;
    goto_line(53);
    step(80, 53, 0, 1, FG);
    step(1, 53, 0, 1, BD);
    step(1, 53, 0, 1, BD);
    check("font_addr_c1", {21'h0, font_addr}, 32'h412);
    flush(53);
    for (int h = 16; h < 32; h++) begin
      logic [7:0] g;
      g = 8'hCA;
      step(64 + h, 53, 0, 1, g[7 - (h % 8)] ? FG : BG);
    end
    flush(53);
    font[11'h412] = 8'h80;
    vram[2] = 8'h41;

    // Reset mid-frame while a foreground pixel is on the output.
    goto_line(200);
    for (int x = 290; x <= 300; x++) step_m(x, 200, 0);
    check("pre_reset_rgb", {8'h0, rgb}, {8'h0, FG});
    resetn = 1'b0;
    #1;
    check("mid_reset_rgb", {8'h0, rgb}, 32'h0);
    check("mid_reset_vram_addr", {22'h0, vram_addr}, 32'h0);
    check("mid_reset_font_addr", {21'h0, font_addr}, 32'h0);
    for (int i = 0; i < 5; i++) chk_p[i] = 0;
    repeat (2) @(posedge clk_pixel);
    #1;
    resetn = 1'b1;
    cur_y = 0;
    for (int x = 64; x < 72; x++) begin
      step_m(x, 201, 0);
      if (x < 68) check("post_reset_zero", {8'h0, rgb}, 32'h0);
    end
    flush(201);
    vram[0] = 8'h81;
    run(48, 60, 90, 0);
    run(55, 60, 90, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
